// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings, FSM states and reset level shared by pipe_ctrl
package pipe_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX_MULTI = 6'b001111;
  localparam logic RESET_ENABLE = 1'b0;
  typedef enum logic {IDLE = 1'b0, MULTI = 1'b1} state_t;
endpackage

// File: rtl/pipe_ctrl_mc_down_counter.sv
// mc_down_counter: loadable down-counter for multi-cycle EX holds; flags the final count
module mc_down_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         is_one
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE || clr) cnt <= '0;
    else if (load) cnt <= din;
    else if (dec) cnt <= cnt - 1'b1;
  end
  assign is_one = cnt == W'(1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer; `define PIPE_CTRL_STALL_CNT_EN adds a saturating stall-cycle counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int ADDR_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stallreq_id,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                flush_req,
  input  logic [ADDR_W-1:0]   flush_pc,
  output logic [STALL_W-1:0]  stall,
  output logic                flush,
  output logic [ADDR_W-1:0]   new_pc,
  output logic                ex_mc_busy,
  output logic                ex_mc_last,
  output logic [31:0]         stall_cycles
);
  state_t state, state_nxt;
  logic rst_act, cnt_clr, cnt_load, cnt_dec, cnt_one;
  assign rst_act = reset == RESET_ENABLE;
  always_ff @(posedge clock) state <= rst_act ? IDLE : state_nxt;
  always_comb begin
    state_nxt  = state;
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = '0;
    ex_mc_last = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (rst_act) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end else if (flush_req) begin
      flush     = 1'b1;
      new_pc    = flush_pc;
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end else if (state == MULTI) begin
      stall      = STALL_EX_MULTI;
      cnt_dec    = 1'b1;
      ex_mc_last = cnt_one;
      state_nxt  = cnt_one ? IDLE : MULTI;
    end else if (ex_mc_start && ex_mc_cycles != '0) begin
      // a length-1 op completes in its start cycle, so no MULTI visit
      stall      = STALL_EX_MULTI;
      ex_mc_last = ex_mc_cycles == MC_CNT_W'(1);
      cnt_load   = !ex_mc_last;
      state_nxt  = ex_mc_last ? IDLE : MULTI;
    end else if (stallreq_id) begin
      stall = STALL_LOAD_USE;
    end
  end
  assign ex_mc_busy = !rst_act && state == MULTI;
  mc_down_counter #(.W(MC_CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .din   (ex_mc_cycles - 1'b1),
    .is_one(cnt_one)
  );
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] sc_q;
  always_ff @(posedge clock) begin
    if (rst_act) sc_q <= '0;
    else if (stall != STALL_NONE && sc_q != '1) sc_q <= sc_q + 1'b1;
  end
  assign stall_cycles = rst_act ? '0 : sc_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench; stimulus pushes model expectations, a negedge monitor checks them
module tb_pipe_ctrl;
  logic        clock = 1'b0;
  logic        reset, stallreq_id, ex_mc_start, flush_req;
  logic [5:0]  ex_mc_cycles;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush, ex_mc_busy, ex_mc_last;
  logic [31:0] new_pc, stall_cycles;

  pipe_ctrl dut (
    .clock(clock), .reset(reset), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_busy(ex_mc_busy),
    .ex_mc_last(ex_mc_last), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic        last;
    logic [31:0] sc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;

  // model: number of pipeline-hold cycles still owed after the current one, plus stall tally
  int unsigned owed = 0;
  int unsigned tally = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input logic rn, input logic fr, input logic [31:0] fpc,
                     input logic st, input logic [5:0] n, input logic id);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rn; flush_req = fr; flush_pc = fpc;
    ex_mc_start = st; ex_mc_cycles = n; stallreq_id = id;
    e = '{stall: 6'd0, flush: 1'b0, new_pc: 32'd0, busy: 1'b0, last: 1'b0, sc: 32'd0};
    if (!rn) begin
      owed = 0;
      tally = 0;
    end else begin
      e.busy = owed > 0;
`ifdef PIPE_CTRL_STALL_CNT_EN
      e.sc = tally;
`endif
      if (fr) begin
        e.flush = 1'b1;
        e.new_pc = fpc;
        owed = 0;
      end else if (owed > 0) begin
        e.stall = 6'b001111;
        owed--;
        e.last = owed == 0;
      end else if (st && n > 0) begin
        e.stall = 6'b001111;
        owed = n - 1;
        e.last = owed == 0;
      end else if (id) begin
        e.stall = 6'b000111;
      end
      if (e.stall != 0 && tally != 32'hFFFF_FFFF) tally++;
    end
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("new_pc", new_pc, e.new_pc);
      chk("ex_mc_busy", 32'(ex_mc_busy), 32'(e.busy));
      chk("ex_mc_last", 32'(ex_mc_last), 32'(e.last));
      chk("stall_cycles", stall_cycles, e.sc);
    end
  end

  initial begin
    reset = 1'b0; flush_req = 1'b1; flush_pc = 32'h1234; ex_mc_start = 1'b1;
    ex_mc_cycles = 6'd4; stallreq_id = 1'b1;
    // reset while every request is active
    cyc(0, 1, 32'h1234, 1, 6'd4, 1);
    cyc(0, 1, 32'h1234, 1, 6'd4, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 6'd4, 0);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 6'd1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 6'd0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 6'd5, 0);
    cyc(1, 0, 0, 1, 6'd7, 1);
    cyc(1, 1, 32'h0000_0180, 1, 6'd3, 1);
    cyc(1, 0, 0, 0, 0, 0);
    // N=3 then a load-use stall from a fresh reset: tally ends at 4
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 6'd3, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 6'd6, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [5:0] n;
      n = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 11) == 0, $urandom,
          $urandom_range(0, 3) == 0, n, $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
